fifo_wr_sched: RTL and testbench
================================

# fifo_wr_sched

Write/read scheduler for the shared byte FIFO (`fifo`). Two producers share the FIFO write port through a round-robin arbiter with a burst limit. A single consumer drains the FIFO through a gated read strobe. The block keeps its own occupancy count, so grants never overflow the FIFO and reads never underflow it, even with the one-cycle registered write path. It sits between the producer blocks and the `fifo` instance, and drives `wr`, `w_data` and `rd`.

## Interface
- `B`, 8: data width, matches FIFO `w_data`/`r_data`.
- `DEPTH`, 16: FIFO capacity in words; the occupancy counter saturates logic at this value.
- `BURST`, 4: maximum consecutive grants to one requester while the other is requesting.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous and active-low.
- `req0`  in  1  requester 0 has a word; `data0` is held stable while `req0`=1.
- `data0`  in  B  requester 0 write data.
- `gnt0`  out  1  combinational; a transfer occurs at the edge where `req0 & gnt0`.
- `req1`, `data1`, `gnt1`  same as above, for requester 1.
- `take`  in  1  consumer requests one word.
- `full`  in  1  FIFO full flag.
- `empty`  in  1  FIFO empty flag.
- `wr`  out  1  registered FIFO write strobe.
- `w_data`  out  B  registered FIFO write data.
- `rd`  out  1  combinational FIFO read strobe.
- `count`  out  $clog2(DEPTH+1)  committed occupancy, including a write in flight.

## Operation
- **Occupancy counter.**
  - `count_nxt = count + acc - rd`, where `acc = (req0&gnt0)|(req1&gnt1)`.
  - Landed words: `landed = count - wr`, i.e. words already inside the FIFO.
- **Grant eligibility.**
  - `elig = (count < DEPTH) & ~full & rst`.
  - No same-cycle credit from `rd`: at `count==DEPTH` there is no grant even when `rd`=1.
- **Arbiter.**
  - States: `OWN0` and `OWN1`. The owner is the preferred requester.
  - A burst counter `bcnt` tracks consecutive grants to the current owner.
- **Arbiter transitions.**
  - Only the owner requests: grant the owner; `bcnt++`.
  - Only the non-owner requests: grant it; switch owner; `bcnt=1`.
  - Both request and `bcnt<BURST`: grant the owner; `bcnt++`.
  - Both request and `bcnt==BURST`: grant the non-owner; switch owner; `bcnt=1`.
  - Neither requests, or `elig`=0: no grant; state and `bcnt` are held.
- **Grant outputs.** At most one of `gnt0`/`gnt1` is high in any cycle. A grant is never asserted without the matching request.
- **Write path.** On an accepted transfer, the next edge registers `wr<=1` and `w_data<=` the granted data. Otherwise `wr<=0` and `w_data` is held.
- **Read path.** `rd = take & (landed != 0) & ~empty`.
- **Simultaneous accept and read.** `count` is unchanged.
- **Reset (`rst`=0 at an edge).**
  - Register values: `wr=0`, `w_data=0`, `count=0`, state `OWN0`, `bcnt=0`.
  - While `rst`=0, `gnt0`, `gnt1` and `rd` are forced to 0.
  - Reset mid-operation drops any in-flight write; the FIFO shares `rst`.

## Timing
- Grant decision: zero-cycle, combinational from `req*`, `count` and `full`.
- Write latency: accept at edge k gives `wr`/`w_data` valid in cycle k..k+1, so the FIFO writes at edge k+1.
- Throughput: one write per cycle sustained.
- Read: `rd` is combinational, and the FIFO pops at the same edge. `r_data` timing is owned by `fifo`.
- A word accepted at edge k is readable from edge k+2; `landed` excludes it until then.

## Configuration
- `FIFO_SCHED_STRICT_PRIO_EN` defined:
  - Requester 0 always wins when both request.
  - `BURST` and `bcnt` are unused, and requester 1 can starve.
- `FIFO_SCHED_STRICT_PRIO_EN` undefined: round-robin with the `BURST` limit, as described in Operation.

## Structure
- Package `fifo_sched_pkg` holds:
  - the arbiter state encoding (`OWN0`, `OWN1`);
  - the `CNT_W = $clog2(DEPTH+1)` helper;
  - the default `DEPTH` and `BURST` constants.
- One sub-module, `fifo_rr_arb`: the 2-way burst-limited arbiter (state, `bcnt`, grant logic, strict-priority option). Counter, write register and read gating stay in the top module.

## Test plan
- **Reset.** Hold `rst`=0 for 2 cycles with `req0`=1 -> `gnt0`=0, `wr`=0, `count`=0. Release, then `data0`=8'hda -> the next cycle has `wr`=1, `w_data`=8'hda, `count`=1.
- **Round-robin.** `req0`=`req1`=1 continuously, `data0`=8'h31, `data1`=8'h0e, `take`=1 -> grant order 0,0,0,0,1,1,1,1,0… The `w_data` stream mirrors this order, one word per cycle.
- **Fill.** `req0`=1, `take`=0 -> exactly 16 grants, then `gnt0`=0 with `count`=16 and `wr` deasserted. No write ever occurs with `full`=1.
- **Drain.** After the fill, `take`=1 -> exactly 16 `rd` pulses and `count` reaches 0. `rd` stays 0 afterwards although `take`=1.
- **Simultaneous.** At `count`=5 with `req1`=1 (`data1`=8'he1) and `take`=1 -> `count` stays 5 and `rd`=1. The next cycle has `wr`=1, `w_data`=8'he1.
- **Strict priority.** With `FIFO_SCHED_STRICT_PRIO_EN` defined and both requesting for 10 cycles -> 10 grants to requester 0, none to requester 1.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sched_pkg
// Shared definitions for the FIFO write/read scheduler (fifo_wr_sched) and its
// round-robin arbiter (fifo_rr_arb):
//   - arb_state_t : arbiter owner encoding (OWN0 / OWN1)
//   - cnt_w()     : occupancy counter width for a given FIFO depth
//   - other_own() : the owner that is not the given one
//   - DEF_*       : default data width, FIFO depth and burst limit
// Optional build macro used by the arbiter: FIFO_SCHED_STRICT_PRIO_EN.
// -----------------------------------------------------------------------------
package fifo_sched_pkg;

  // Arbiter owner: the owner is the preferred requester when both ask.
  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } arb_state_t;

  localparam int DEF_B     = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_BURST = 4;

  // The counter must be able to hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_DEPTH);

  function automatic arb_state_t other_own(input arb_state_t s);
    return (s == OWN0) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/fifo_rr_arb.sv
// -----------------------------------------------------------------------------
// fifo_rr_arb
// Two-way burst-limited round-robin arbiter for the shared FIFO write port.
// Grants are combinational; owner state and burst counter are registered.
//
// Parameters:
//   BURST  maximum consecutive grants to the owner while the other requests
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-low reset
//   elig   in   a grant may be issued this cycle (room in FIFO, not in reset)
//   req0   in   requester 0 has a word
//   req1   in   requester 1 has a word
//   gnt0   out  grant to requester 0 (combinational, never without req0)
//   gnt1   out  grant to requester 1 (combinational, never without req1)
//
// Build option: FIFO_SCHED_STRICT_PRIO_EN defined makes requester 0 win every
// contested cycle; the owner/burst state then has no effect on the grants.
// -----------------------------------------------------------------------------
module fifo_rr_arb
  import fifo_sched_pkg::*;
#(
  parameter int BURST = DEF_BURST
) (
  input  logic clk,
  input  logic rst,
  input  logic elig,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam int            BW   = $clog2(BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST);
  localparam logic [BW-1:0] BONE = BW'(1);

  arb_state_t    state;
  logic [BW-1:0] bcnt;

  logic own_req;
  logic oth_req;
  logic pick_own;
  logic pick_oth;

  // Grant decision, expressed relative to the current owner.
  always_comb begin
    own_req  = (state == OWN0) ? req0 : req1;
    oth_req  = (state == OWN0) ? req1 : req0;
    pick_own = 1'b0;
    pick_oth = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
`ifdef FIFO_SCHED_STRICT_PRIO_EN
    gnt0     = elig & req0;
    gnt1     = elig & req1 & ~req0;
    pick_own = (state == OWN0) ? gnt0 : gnt1;
    pick_oth = (state == OWN0) ? gnt1 : gnt0;
`else
    if (elig) begin
      if (own_req && oth_req) begin
        // Contested: the owner keeps the port until its burst is used up.
        if (bcnt < BMAX) begin
          pick_own = 1'b1;
        end else begin
          pick_oth = 1'b1;
        end
      end else begin
        pick_own = own_req;
        pick_oth = oth_req;
      end
    end
    gnt0 = (state == OWN0) ? pick_own : pick_oth;
    gnt1 = (state == OWN0) ? pick_oth : pick_own;
`endif
  end

  // Owner / burst bookkeeping. bcnt saturates at BURST so that an
  // uncontested owner streak cannot wrap and reopen a fresh burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= OWN0;
      bcnt  <= '0;
    end else if (pick_own) begin
      bcnt  <= (bcnt == BMAX) ? BMAX : bcnt + BONE;
    end else if (pick_oth) begin
      state <= other_own(state);
      bcnt  <= BONE;
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// -----------------------------------------------------------------------------
// fifo_wr_sched
// Write/read scheduler for the shared byte FIFO. Two producers share the FIFO
// write port via a burst-limited round-robin arbiter; one consumer drains it
// through a gated read strobe. A private occupancy count (including the word
// held in the write register) keeps grants from overflowing the FIFO and reads
// from underflowing it.
//
// Parameters:
//   B      data width
//   DEPTH  FIFO capacity in words
//   BURST  max consecutive grants to one requester while the other requests
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-low reset (shared with the FIFO)
//   req0    in   requester 0 has a word (data0 stable while req0=1)
//   data0   in   requester 0 write data
//   gnt0    out  combinational grant to requester 0
//   req1    in   requester 1 has a word (data1 stable while req1=1)
//   data1   in   requester 1 write data
//   gnt1    out  combinational grant to requester 1
//   take    in   consumer requests one word
//   full    in   FIFO full flag
//   empty   in   FIFO empty flag
//   wr      out  registered FIFO write strobe
//   w_data  out  registered FIFO write data
//   rd      out  combinational FIFO read strobe
//   count   out  committed occupancy, including a write in flight
//
// Build option: FIFO_SCHED_STRICT_PRIO_EN (see fifo_rr_arb).
// -----------------------------------------------------------------------------
module fifo_wr_sched
  import fifo_sched_pkg::*;
#(
  parameter int B     = DEF_B,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BURST = DEF_BURST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0,
  input  logic [B-1:0]               data0,
  output logic                       gnt0,
  input  logic                       req1,
  input  logic [B-1:0]               data1,
  output logic                       gnt1,
  input  logic                       take,
  input  logic                       full,
  input  logic                       empty,
  output logic                       wr,
  output logic [B-1:0]               w_data,
  output logic                       rd,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int            CW       = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          elig;
  logic          acc;
  logic [CW-1:0] landed;

  // Eligibility uses the committed count only: a read in this same cycle
  // does not free a slot for a grant until the next cycle.
  assign elig = (count < FULL_CNT) & ~full & rst;

  fifo_rr_arb #(
    .BURST (BURST)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .elig (elig),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign acc = (req0 & gnt0) | (req1 & gnt1);

  // The word sitting in the write register is counted but not yet readable.
  assign landed = count - CW'(wr);
  assign rd     = take & (landed != '0) & ~empty & rst;

  // Stage p0 -> FIFO: registered write strobe and data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr     <= 1'b0;
      w_data <= '0;
    end else begin
      wr <= acc;
      if (acc) begin
        w_data <= gnt1 ? data1 : data0;
      end
    end
  end

  // Occupancy: accept and read in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count + CW'(acc) - CW'(rd);
    end
  end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_sched
// Self-checking bench for fifo_wr_sched. A behavioural model holds the FIFO
// contents as a queue, the in-flight word, and the arbiter as "who got the
// last grant and how many in a row". It drives full/empty from the modelled
// FIFO and predicts grants, rd, count, wr and w_data every cycle.
// Honours FIFO_SCHED_STRICT_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_fifo_wr_sched;

  localparam int DEPTH = 16;
  localparam int BURST = 4;

  logic       clk;
  logic       rst;
  logic       req0, req1, take, full, empty;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, wr, rd;
  logic [7:0] w_data;
  logic [4:0] count;

  fifo_wr_sched #(.B(8), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .data0  (data0),
    .gnt0   (gnt0),
    .req1   (req1),
    .data1  (data1),
    .gnt1   (gnt1),
    .take   (take),
    .full   (full),
    .empty  (empty),
    .wr     (wr),
    .w_data (w_data),
    .rd     (rd),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [7:0] mq[$];
  bit         m_wr   = 1'b0;
  logic [7:0] m_wd   = 8'h00;
  int         last   = 0;
  int         streak = 0;
  bit         e_g0, e_g1, e_rd;

  // Observations captured at the sampling point of the latest cycle.
  int         ng0, ng1, nrd;
  int         gorder[$];
  logic       obs_rd, obs_wr;
  logic [7:0] obs_wd;
  logic [4:0] obs_cnt;

  int exp_order[10];
  int exp_n0, exp_n1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, sample at negedge, advance model.
  task automatic cycle(input logic r, input logic q0, input logic [7:0] d0,
                       input logic q1, input logic [7:0] d1, input logic tk,
                       input bit chk_en);
    int ecnt;
    int id;
    bit elig;
    rst   = r;
    req0  = q0;
    data0 = d0;
    req1  = q1;
    data1 = d1;
    take  = tk;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    ecnt  = mq.size() + (m_wr ? 1 : 0);
    elig  = r && (ecnt < DEPTH) && !full;
    e_g0  = 1'b0;
    e_g1  = 1'b0;
    if (elig) begin
      if (q0 && q1) begin
`ifdef FIFO_SCHED_STRICT_PRIO_EN
        e_g0 = 1'b1;
`else
        if ((streak < BURST) == (last == 0)) e_g0 = 1'b1;
        else e_g1 = 1'b1;
`endif
      end else begin
        e_g0 = q0;
        e_g1 = q1;
      end
    end
    e_rd = r && tk && (mq.size() != 0);

    @(negedge clk);
    obs_rd  = rd;
    obs_wr  = wr;
    obs_wd  = w_data;
    obs_cnt = count;
    if (gnt0 === 1'b1) begin ng0++; gorder.push_back(0); end
    if (gnt1 === 1'b1) begin ng1++; gorder.push_back(1); end
    if (rd === 1'b1) nrd++;
    if (chk_en) begin
      chk("gnt0", 32'(gnt0), 32'(e_g0));
      chk("gnt1", 32'(gnt1), 32'(e_g1));
      chk("rd", 32'(rd), 32'(e_rd));
      chk("count", 32'(count), 32'(ecnt));
      chk("wr", 32'(wr), 32'(m_wr));
      chk("w_data", 32'(w_data), 32'(m_wd));
      chk("wr_while_full", 32'(wr & full), 32'd0);
    end

    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_wr   = 1'b0;
      m_wd   = 8'h00;
      last   = 0;
      streak = 0;
    end else begin
      if (e_rd) void'(mq.pop_front());
      if (m_wr) mq.push_back(m_wd);
      if (e_g0 || e_g1) begin
        id = e_g1 ? 1 : 0;
        if (id == last) streak++;
        else begin
          last   = id;
          streak = 1;
        end
      end
      m_wr = e_g0 || e_g1;
      if (m_wr) m_wd = e_g0 ? d0 : d1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       p0, p1, tk, r;
    logic [7:0] pd0, pd1;
    int         take_pct;

`ifdef FIFO_SCHED_STRICT_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_n0 = 10;
    exp_n1 = 0;
`else
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    exp_n0 = 6;
    exp_n1 = 4;
`endif

    // Power-up: registers unknown until the first reset edge.
    cycle(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset held with a pending request, then first write.
    cycle(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'hda, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("first_wr", 32'(obs_wr), 32'd1);
    chk("first_wdata", 32'(obs_wd), 32'hda);
    chk("first_count", 32'(obs_cnt), 32'd1);

    // Round-robin / strict priority with both requesting.
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    gorder.delete();
    ng0 = 0;
    ng1 = 0;
    repeat (10) cycle(1'b1, 1'b1, 8'h31, 1'b1, 8'h0e, 1'b1, 1'b1);
    chk("arb_len", 32'(gorder.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < gorder.size()) chk("arb_order", 32'(gorder[i]), 32'(exp_order[i]));
    chk("arb_n0", 32'(ng0), 32'(exp_n0));
    chk("arb_n1", 32'(ng1), 32'(exp_n1));

    // Fill from empty with no reads.
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    ng0 = 0;
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 1'b1, (i < 16) ? 8'(8'h40 + i) : 8'h4f, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("fill_grants", 32'(ng0), 32'd16);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_gnt0", 32'(gnt0), 32'd0);
    chk("fill_wr", 32'(wr), 32'd0);

    // Drain everything.
    nrd = 0;
    repeat (20) cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("drain_rd", 32'(nrd), 32'd16);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_rd_idle", 32'(rd), 32'd0);

    // Simultaneous accept and read at count 5.
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b1, 8'h50, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'he1, 1'b1, 1'b1);
    chk("simul_rd", 32'(obs_rd), 32'd1);
    chk("simul_count", 32'(obs_cnt), 32'd5);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("simul_wr", 32'(obs_wr), 32'd1);
    chk("simul_wdata", 32'(obs_wd), 32'he1);
    chk("simul_count2", 32'(obs_cnt), 32'd5);

    // Randomised traffic; producers hold request and data until granted.
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    p0 = 1'b0;
    p1 = 1'b0;
    pd0 = 8'h00;
    pd1 = 8'h00;
    take_pct = 50;
    for (int i = 0; i < 450; i++) begin
      if (i % 75 == 0) take_pct = $urandom_range(5, 95);
      r = ($urandom_range(0, 79) != 0);
      if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; pd0 = 8'($urandom); end
      if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1'b1; pd1 = 8'($urandom); end
      tk = ($urandom_range(0, 99) < take_pct);
      cycle(r, p0, pd0, p1, pd1, tk, 1'b1);
      if (e_g0 || !r) p0 = 1'b0;
      if (e_g1 || !r) p1 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
